// File: rtl/audio_system_clk_gen_pkg.sv
// Shared types for the audio/video clock generator: FSM states, channel
// configuration record and the config-write validity check.
package audio_system_clk_gen_pkg;

   localparam int CFG_W = 32;

   typedef enum logic [1:0] {
      APPLY   = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } clk_state_e;

   typedef enum logic [1:0] {
      REJ_NONE  = 2'd0,
      REJ_DIV   = 2'd1,
      REJ_PHASE = 2'd2,
      REJ_CHAN  = 2'd3
   } cfg_rej_e;

   // Fields are held at full CFG_W width; upper bits above the module's
   // counter width are always zero and fold away in synthesis.
   typedef struct packed {
      logic [CFG_W-1:0] div;
      logic [CFG_W-1:0] high;
      logic [CFG_W-1:0] phase;
   } chan_cfg_t;

   function automatic cfg_rej_e check_cfg(
      input logic [CFG_W-1:0] div,
      input logic [CFG_W-1:0] phase,
      input logic [CFG_W-1:0] chan,
      input logic [CFG_W-1:0] num_clks
   );
      if (chan >= num_clks)
         return REJ_CHAN;
      if (div < CFG_W'(2))
         return REJ_DIV;
      if (phase >= div)
         return REJ_PHASE;
      return REJ_NONE;
   endfunction

endpackage

// File: rtl/audio_system_clk_gen_chan.sv
// One divided-clock channel: wrapping counter, registered high-time compare
// and rising-edge tick. Preloads on load, advances on run, parks low otherwise.
module audio_system_clk_gen_chan
   import audio_system_clk_gen_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  logic      run,
   input  chan_cfg_t cfg,
   output logic      outclk,
   output logic      tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CFG_W-1:0] cnt_nxt_ext;
   logic             wrap;
   logic             tick_en;

   always_comb begin
      wrap    = (CFG_W'(cnt) == (cfg.div - CFG_W'(1)));
      cnt_nxt = cnt;
      // Phase delays the channel: starting at div-phase reaches 0 after phase cycles.
      if (load)
         cnt_nxt = (cfg.phase == '0) ? '0 : CNT_W'(cfg.div - cfg.phase);
      else if (run)
         cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
      cnt_nxt_ext = CFG_W'(cnt_nxt);
      tick_en     = (cfg.high != '0) && (cfg.high < cfg.div);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         outclk <= 1'b0;
         tick   <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (load || run) begin
            outclk <= (cnt_nxt_ext < cfg.high);
            tick   <= tick_en && (cnt_nxt == '0);
         end else begin
            outclk <= 1'b0;
            tick   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/audio_system_clk_gen.sv
// N-channel programmable clock generator: config register file, apply/lock FSM
// and one counter channel per output. Any accepted write resyncs every channel.
module audio_system_clk_gen
   import audio_system_clk_gen_pkg::*;
#(
   parameter  int NUM_CLKS    = 3,
   parameter  int CNT_W       = 16,
   parameter  int DEF_DIV     = 2,
   parameter  int LOCK_CYCLES = 16,
   localparam int CHAN_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CHAN_W-1:0]   cfg_chan,
   input  logic [CNT_W-1:0]    cfg_div,
   input  logic [CNT_W-1:0]    cfg_high,
   input  logic [CNT_W-1:0]    cfg_phase,
   output logic                cfg_err,
   output logic [NUM_CLKS-1:0] outclk,
   output logic [NUM_CLKS-1:0] outclk_tick,
   output logic                locked
);

   localparam int               LOCK_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [CFG_W-1:0]  DIV_RST   = CFG_W'(DEF_DIV);
   localparam logic [CFG_W-1:0]  HIGH_RST  = CFG_W'(DEF_DIV / 2);

   clk_state_e        state;
   logic [LOCK_W-1:0] lock_cnt;
   chan_cfg_t         cfg_r [NUM_CLKS];
   chan_cfg_t         wr_cfg;
   cfg_rej_e          wr_rej;
   logic              wr_acc;
   logic              wr_ok;
   logic              chan_load;
   logic              chan_run;

   always_comb begin
      wr_cfg       = '0;
      wr_cfg.div   = CFG_W'(cfg_div);
      wr_cfg.high  = CFG_W'(cfg_high);
      wr_cfg.phase = CFG_W'(cfg_phase);
      wr_rej       = check_cfg(wr_cfg.div, wr_cfg.phase, CFG_W'(cfg_chan), CFG_W'(NUM_CLKS));
      wr_acc       = cfg_valid && cfg_ready;
      wr_ok        = wr_acc && (wr_rej == REJ_NONE);
      // Channels preload at the end of APPLY and freeze low on the edge entering it.
      chan_load    = (state == APPLY);
      chan_run     = (state != APPLY) && !wr_ok;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= APPLY;
         lock_cnt  <= '0;
         locked    <= 1'b0;
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
         for (int i = 0; i < NUM_CLKS; i++) begin
            cfg_r[i].div   <= DIV_RST;
            cfg_r[i].high  <= HIGH_RST;
            cfg_r[i].phase <= '0;
         end
      end else begin
         cfg_err <= wr_acc && (wr_rej != REJ_NONE);

         if (wr_ok) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
               if (CFG_W'(i) == CFG_W'(cfg_chan))
                  cfg_r[i] <= wr_cfg;
            end
         end

         case (state)
            APPLY: begin
               state     <= LOCKING;
               lock_cnt  <= '0;
               locked    <= 1'b0;
               cfg_ready <= 1'b1;
            end
            LOCKING: begin
               if (wr_ok) begin
                  state     <= APPLY;
                  cfg_ready <= 1'b0;
               end else if (lock_cnt == LOCK_LAST) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + LOCK_W'(1);
               end
            end
            LOCKED: begin
               if (wr_ok) begin
                  state     <= APPLY;
                  locked    <= 1'b0;
                  cfg_ready <= 1'b0;
               end
            end
            default: begin
               state     <= APPLY;
               locked    <= 1'b0;
               cfg_ready <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CLKS; i++) begin : g_chan
      audio_system_clk_gen_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk    (refclk),
         .rst    (rst),
         .load   (chan_load),
         .run    (chan_run),
         .cfg    (cfg_r[i]),
         .outclk (outclk[i]),
         .tick   (outclk_tick[i])
      );
   end

endmodule
